// File: rtl/bsg_store_and_forward_filtered.sv
// Store-and-forward packet buffer: a packet becomes visible to the consumer only
// after its last beat is stored and it survives the size, overflow and error filters.
module bsg_store_and_forward_filtered #(
  parameter int width_p                  = 8,
  parameter int els_p                    = 8,
  parameter int max_pkt_els_p            = els_p,
  parameter bit write_no_backpressure_p  = 1'b0,
  parameter bit drop_bad_p               = 1'b0,
  localparam int pkt_cnt_width_lp        = $clog2(els_p + 1)
) (
  input  logic                        clk_i,
  input  logic                        reset_i,

  input  logic [width_p-1:0]          data_i,
  input  logic                        v_i,
  input  logic                        last_i,
  input  logic                        error_i,
  output logic                        ready_o,

  output logic [width_p-1:0]          data_o,
  output logic                        v_o,
  output logic                        last_o,
  input  logic                        yumi_i,

  output logic                        good_packet_o,
  output logic                        bad_packet_o,
  output logic                        incomplete_packet_o,
  output logic                        oversize_packet_o,
  output logic [pkt_cnt_width_lp-1:0] pkt_count_o
);

  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int len_w_lp = $clog2(max_pkt_els_p + 1);
  localparam logic [idx_w_lp-1:0] last_idx_lp = idx_w_lp'(els_p - 1);
  localparam logic [len_w_lp-1:0] max_len_lp  = len_w_lp'(max_pkt_els_p);

  // Wrap bit distinguishes full from empty when the indices coincide.
  typedef struct packed {
    logic                wrap;
    logic [idx_w_lp-1:0] idx;
  } ptr_t;

  typedef enum logic { RECV = 1'b0, DROP = 1'b1 } state_e;
  typedef enum logic { REASON_BIG = 1'b0, REASON_OVF = 1'b1 } reason_e;

  function automatic ptr_t ptr_inc(input ptr_t p);
    ptr_t r;
    if (p.idx == last_idx_lp) begin
      r.wrap = ~p.wrap;
      r.idx  = '0;
    end else begin
      r.wrap = p.wrap;
      r.idx  = p.idx + idx_w_lp'(1);
    end
    return r;
  endfunction

  logic [width_p:0] mem_r [els_p];

  ptr_t    wptr_r, cptr_r, rptr_r;
  ptr_t    wptr_n, cptr_n, wptr_inc;
  state_e  state_r, state_n;
  reason_e reason_r, reason_n;
  logic [len_w_lp-1:0] len_r, len_n;

  logic full, committed_empty, overflow, accept;
  logic cause_ovf, cause_big;
  logic wr_en, commit, pop_last;
  logic good_n, bad_n, incomplete_n, oversize_n;

  assign full            = (wptr_r.idx == rptr_r.idx) && (wptr_r.wrap != rptr_r.wrap);
  assign committed_empty = (cptr_r == rptr_r);
  // Storage is full of an uncommitted packet: it can never complete, so keep draining it.
  assign overflow        = full & committed_empty;

  assign ready_o = write_no_backpressure_p | (state_r == DROP) | overflow | ~full;
  assign accept  = v_i & ready_o;

  assign v_o              = ~committed_empty;
  assign {last_o, data_o} = mem_r[rptr_r.idx];
  assign pop_last         = yumi_i & last_o;

  assign wptr_inc  = ptr_inc(wptr_r);
  assign cause_ovf = (full & write_no_backpressure_p) | overflow;
  assign cause_big = (len_r == max_len_lp);

  // NOTE: every signal gets a default before any branch so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    wr_en        = 1'b0;
    commit       = 1'b0;
    wptr_n       = wptr_r;
    cptr_n       = cptr_r;
    state_n      = state_r;
    reason_n     = reason_r;
    len_n        = len_r;
    good_n       = 1'b0;
    bad_n        = 1'b0;
    incomplete_n = 1'b0;
    oversize_n   = 1'b0;

    if (accept) begin
      unique case (state_r)
        RECV: begin
          if (cause_ovf | cause_big) begin
            wptr_n   = cptr_r;
            len_n    = '0;
            reason_n = cause_ovf ? REASON_OVF : REASON_BIG;
            if (last_i) begin
              incomplete_n = cause_ovf;
              oversize_n   = ~cause_ovf;
            end else begin
              state_n = DROP;
            end
          end else begin
            wr_en  = 1'b1;
            wptr_n = wptr_inc;
            len_n  = len_r + len_w_lp'(1);
            if (last_i) begin
              len_n = '0;
              if (error_i & drop_bad_p) begin
                wptr_n = cptr_r;
                bad_n  = 1'b1;
              end else begin
                cptr_n = wptr_inc;
                commit = 1'b1;
                good_n = ~error_i;
                bad_n  = error_i;
              end
            end
          end
        end
        DROP: begin
          if (last_i) begin
            state_n      = RECV;
            incomplete_n = (reason_r == REASON_OVF);
            oversize_n   = (reason_r == REASON_BIG);
          end
        end
        default: state_n = RECV;
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r              <= '0;
      cptr_r              <= '0;
      rptr_r              <= '0;
      state_r             <= RECV;
      reason_r            <= REASON_BIG;
      len_r               <= '0;
      pkt_count_o         <= '0;
      good_packet_o       <= 1'b0;
      bad_packet_o        <= 1'b0;
      incomplete_packet_o <= 1'b0;
      oversize_packet_o   <= 1'b0;
    end else begin
      wptr_r              <= wptr_n;
      cptr_r              <= cptr_n;
      state_r             <= state_n;
      reason_r            <= reason_n;
      len_r               <= len_n;
      good_packet_o       <= good_n;
      bad_packet_o        <= bad_n;
      incomplete_packet_o <= incomplete_n;
      oversize_packet_o   <= oversize_n;
      if (yumi_i) rptr_r <= ptr_inc(rptr_r);
      unique case ({commit, pop_last})
        2'b10:   pkt_count_o <= pkt_count_o + pkt_cnt_width_lp'(1);
        2'b01:   pkt_count_o <= pkt_count_o - pkt_cnt_width_lp'(1);
        default: pkt_count_o <= pkt_count_o;
      endcase
    end
  end

  // NOTE: the storage array has no reset; pointers guard every read, so its contents never matter after reset.
  always_ff @(posedge clk_i) begin
    if (wr_en) mem_r[wptr_r.idx] <= {last_i, data_i};
  end

  a_yumi_needs_valid: assert property (@(posedge clk_i) disable iff (reset_i) yumi_i |-> v_o)
    else $error("yumi_i asserted while v_o is low");

  a_params_legal: assert property (@(posedge clk_i)
    (max_pkt_els_p >= 1) && (max_pkt_els_p <= els_p) && (els_p >= 2))
    else $error("illegal parameters: need 1 <= max_pkt_els_p <= els_p and els_p >= 2");

endmodule

// File: tb/tb_bsg_store_and_forward_filtered.sv
// Bench for the filtered store-and-forward buffer: three configurations checked
// every cycle against a packet-level queue model.
module tb_bsg_store_and_forward_filtered;

  localparam int ELS = 8;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [7:0] data_i = '0;
  logic       last_i = 1'b0;
  logic       error_i = 1'b0;
  logic [2:0] v_i = '0;
  logic [2:0] yumi_i = '0;

  logic [2:0] ready_o, v_o, last_o, good_o, bad_o, inc_o, ovs_o;
  logic [7:0] data_o [3];
  logic [3:0] cnt_o  [3];

  always #5 clk = ~clk;

  // 0: max 4, drop bad; 1: max 4, forward bad; 2: max 8, no backpressure
  bsg_store_and_forward_filtered #(.width_p(8), .els_p(ELS), .max_pkt_els_p(4),
    .write_no_backpressure_p(1'b0), .drop_bad_p(1'b1)) u_a (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i[0]), .last_i(last_i),
    .error_i(error_i), .ready_o(ready_o[0]), .data_o(data_o[0]), .v_o(v_o[0]),
    .last_o(last_o[0]), .yumi_i(yumi_i[0]), .good_packet_o(good_o[0]),
    .bad_packet_o(bad_o[0]), .incomplete_packet_o(inc_o[0]),
    .oversize_packet_o(ovs_o[0]), .pkt_count_o(cnt_o[0]));

  bsg_store_and_forward_filtered #(.width_p(8), .els_p(ELS), .max_pkt_els_p(4),
    .write_no_backpressure_p(1'b0), .drop_bad_p(1'b0)) u_b (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i[1]), .last_i(last_i),
    .error_i(error_i), .ready_o(ready_o[1]), .data_o(data_o[1]), .v_o(v_o[1]),
    .last_o(last_o[1]), .yumi_i(yumi_i[1]), .good_packet_o(good_o[1]),
    .bad_packet_o(bad_o[1]), .incomplete_packet_o(inc_o[1]),
    .oversize_packet_o(ovs_o[1]), .pkt_count_o(cnt_o[1]));

  bsg_store_and_forward_filtered #(.width_p(8), .els_p(ELS), .max_pkt_els_p(8),
    .write_no_backpressure_p(1'b1), .drop_bad_p(1'b0)) u_c (
    .clk_i(clk), .reset_i(reset_i), .data_i(data_i), .v_i(v_i[2]), .last_i(last_i),
    .error_i(error_i), .ready_o(ready_o[2]), .data_o(data_o[2]), .v_o(v_o[2]),
    .last_o(last_o[2]), .yumi_i(yumi_i[2]), .good_packet_o(good_o[2]),
    .bad_packet_o(bad_o[2]), .incomplete_packet_o(inc_o[2]),
    .oversize_packet_o(ovs_o[2]), .pkt_count_o(cnt_o[2]));

  // ---------------- reference model ----------------
  typedef struct packed { logic [7:0] d; logic l; } beat_t;
  typedef enum int { P_NONE, P_GOOD, P_BAD, P_INC, P_OVS } pulse_e;

  int     sel;
  int     m_max;
  bit     m_wnb, m_drop_bad;
  beat_t  q_out[$];   // committed beats awaiting the consumer
  beat_t  q_cur[$];   // beats of the packet being received
  bit     m_dropping, m_reason_ovf;
  pulse_e m_pulse;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed=%0h expected=%0h (dut %0d, t=%0t)", tag, obs, exp, sel, $time);
    end
  endtask

  function automatic bit model_ready();
    int occ = q_out.size() + q_cur.size();
    return m_wnb || m_dropping || (occ < ELS) || (q_out.size() == 0);
  endfunction

  function automatic int model_pkts();
    int n = 0;
    foreach (q_out[i]) if (q_out[i].l) n++;
    return n;
  endfunction

  task automatic model_clear();
    q_out.delete();
    q_cur.delete();
    m_dropping   = 1'b0;
    m_reason_ovf = 1'b0;
    m_pulse      = P_NONE;
  endtask

  task automatic model_step(input bit acc, input logic [7:0] d, input bit l, input bit e, input bit y);
    int    occ;
    bit    full, oflow, ovf, big;
    beat_t b;
    occ   = q_out.size() + q_cur.size();
    full  = (occ == ELS);
    oflow = full && (q_out.size() == 0);
    m_pulse = P_NONE;
    if (y) void'(q_out.pop_front());
    if (acc) begin
      if (m_dropping) begin
        if (l) begin
          m_pulse    = m_reason_ovf ? P_INC : P_OVS;
          m_dropping = 1'b0;
        end
      end else begin
        ovf = (full && m_wnb) || oflow;
        big = (q_cur.size() == m_max);
        if (ovf || big) begin
          m_reason_ovf = ovf;
          q_cur.delete();
          if (l) m_pulse = ovf ? P_INC : P_OVS;
          else   m_dropping = 1'b1;
        end else begin
          b.d = d;
          b.l = l;
          q_cur.push_back(b);
          if (l) begin
            if (e && m_drop_bad) begin
              m_pulse = P_BAD;
            end else begin
              foreach (q_cur[i]) q_out.push_back(q_cur[i]);
              m_pulse = e ? P_BAD : P_GOOD;
            end
            q_cur.delete();
          end
        end
      end
    end
  endtask

  task automatic check_outputs();
    check("v_o", v_o[sel], q_out.size() != 0);
    if (q_out.size() != 0) begin
      check("data_o", data_o[sel], q_out[0].d);
      check("last_o", last_o[sel], q_out[0].l);
    end
    check("pkt_count_o", cnt_o[sel], model_pkts());
    check("ready_o", ready_o[sel], model_ready());
    check("good_packet_o", good_o[sel], m_pulse == P_GOOD);
    check("bad_packet_o", bad_o[sel], m_pulse == P_BAD);
    check("incomplete_packet_o", inc_o[sel], m_pulse == P_INC);
    check("oversize_packet_o", ovs_o[sel], m_pulse == P_OVS);
  endtask

  // ---------------- stimulus helpers ----------------
  // One clock: check at negedge, drive, then advance the model at posedge.
  task automatic cycle(input bit v, input logic [7:0] d, input bit l, input bit e,
                       input bit y, output bit acc);
    bit y_now;
    @(negedge clk);
    check_outputs();
    y_now   = y && (q_out.size() != 0);
    v_i     = '0;
    yumi_i  = '0;
    v_i[sel]    = v;
    yumi_i[sel] = y_now;
    data_i  = d;
    last_i  = l;
    error_i = e;
    acc     = v && model_ready();
    @(posedge clk);
    model_step(acc, d, l, e, y_now);
  endtask

  function automatic bit pick_yumi(input int mode);
    return (mode == 1) || ((mode == 2) && ($urandom_range(1) == 1));
  endfunction

  task automatic send_pkt(input int len, input logic [7:0] base, input bit err, input int ymode);
    bit acc;
    for (int i = 0; i < len; i++) begin
      acc = 1'b0;
      for (int t = 0; t < 64 && !acc; t++)
        cycle(1'b1, base + 8'(i), i == len - 1, err && (i == len - 1), pick_yumi(ymode), acc);
      if (!acc) begin
        n_checks++;
        n_fail++;
        $error("FAIL accept_timeout: beat %0d of packet base %0h never accepted", i, base);
      end
    end
  endtask

  task automatic idle(input int n, input int ymode);
    bit acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, 1'b0, 1'b0, pick_yumi(ymode), acc);
  endtask

  task automatic select_dut(input int s);
    sel        = s;
    m_max      = (s == 2) ? 8 : 4;
    m_wnb      = (s == 2);
    m_drop_bad = (s == 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_i = 1'b1;
    v_i     = '0;
    yumi_i  = '0;
    #1;
    model_clear();
    check_outputs();
    @(negedge clk);
    reset_i = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    select_dut(1);
    model_clear();
    do_reset();

    // 3-beat good packet, then read it out
    send_pkt(3, 8'h11, 1'b0, 0);
    idle(2, 0);
    idle(4, 1);

    // oversize: 5 beats (last on the offending beat) and 6 beats (goes through DROP)
    send_pkt(5, 8'h41, 1'b0, 0);
    idle(1, 0);
    send_pkt(6, 8'h51, 1'b0, 0);
    idle(1, 0);
    send_pkt(2, 8'h61, 1'b0, 0);
    idle(1, 0);
    idle(3, 1);

    // error packet: dropped by dut 0, forwarded by dut 1
    select_dut(0);
    do_reset();
    send_pkt(2, 8'h71, 1'b1, 0);
    idle(3, 0);
    select_dut(1);
    do_reset();
    send_pkt(2, 8'h81, 1'b1, 0);
    idle(2, 0);
    idle(3, 1);

    // no-backpressure overflow: 6 committed, then 4-beat packet overflows
    select_dut(2);
    do_reset();
    send_pkt(6, 8'h91, 1'b0, 0);
    send_pkt(4, 8'hA1, 1'b0, 0);
    idle(2, 0);
    idle(7, 1);

    // reset in the middle of a packet while another is waiting
    select_dut(1);
    do_reset();
    send_pkt(2, 8'hB1, 1'b0, 0);
    send_pkt(2, 8'hC1, 1'b0, 0);   // last_i on the second beat commits it
    begin
      bit acc;
      cycle(1'b1, 8'hD1, 1'b0, 1'b0, 1'b0, acc);
      cycle(1'b1, 8'hD2, 1'b0, 1'b0, 1'b0, acc);
    end
    do_reset();
    send_pkt(3, 8'hE1, 1'b0, 0);
    idle(5, 1);

    // back-to-back 2-beat packets with consumer always ready; wraps storage
    for (int p = 0; p < 7; p++) send_pkt(2, 8'(8'h10 * p + 8'h03), 1'b0, 1);
    idle(4, 1);

    // randomized traffic on each configuration
    for (int s = 0; s < 3; s++) begin
      select_dut(s);
      do_reset();
      for (int p = 0; p < 25; p++) begin
        send_pkt($urandom_range(6, 1), 8'($urandom), $urandom_range(3) == 0, 2);
        if ($urandom_range(2) == 0) idle($urandom_range(3, 1), 2);
      end
      idle(20, 1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
